// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - command/response codes, FSM state encoding and byte helper for debug_command_unit
package debug_pkg;

  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam logic [7:0] RSP_STEP = 8'h53;
  localparam logic [7:0] RSP_END  = 8'h45;
  localparam logic [7:0] RSP_HALT = 8'h48;
  localparam logic [7:0] RSP_ERR  = 8'h3F;
  localparam logic [7:0] RSP_EOL  = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_STEP,
    ST_RUN,
    ST_DONE_RSP,
    ST_HALT_RSP,
    ST_ERR_RSP,
    ST_DUMP_WAIT,
    ST_DUMP_SEND,
    ST_EOL
  } state_t;

  // Byte n of a word, counted from the most significant end.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
    logic [7:0] b;
    case (n)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_command_unit_if.sv
// rtl/debug_command_unit_if.sv - UART FIFO and datapath debug signals of debug_command_unit
interface debug_command_unit_if #(
  parameter int IDX_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_available;
  logic             rx_read;
  logic [7:0]       tx_data;
  logic             tx_write;
  logic             pipe_enable;
  logic             program_done;
  logic [IDX_W-1:0] dump_index;
  logic [31:0]      dump_data;
  logic             busy;

  modport master (
    input  rx_data, rx_available, program_done, dump_data,
    output rx_read, tx_data, tx_write, pipe_enable, dump_index, busy
  );

  modport slave (
    output rx_data, rx_available, program_done, dump_data,
    input  rx_read, tx_data, tx_write, pipe_enable, dump_index, busy
  );
endinterface

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - emits a 32-bit word as 4 bytes MSB-first on consecutive cycles
module debug_word_serializer
  import debug_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_word,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done,
  output logic        o_busy
);

  logic        r_active;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active <= 1'b0;
      r_cnt    <= 2'd0;
      r_word   <= 32'd0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_cnt    <= 2'd1;
      r_word   <= i_word;
    end else if (r_active) begin
      r_active <= (r_cnt != 2'd3);
      r_cnt    <= r_cnt + 2'd1;
    end
  end

  // Byte 0 goes out combinationally in the start cycle so a word costs exactly 4 cycles.
  assign o_data  = r_active ? word_byte(r_word, r_cnt) : word_byte(i_word, 2'd0);
  assign o_valid = r_active | i_start;
  assign o_done  = r_active && (r_cnt == 2'd3);
  assign o_busy  = r_active;

endmodule

// File: rtl/debug_command_unit.sv
// rtl/debug_command_unit.sv - host debug command unit: step/run/halt of the datapath and state dump over UART
// Optional cycle-counter word appended to each dump: DEBUG_CYCLE_COUNT_EN
module debug_command_unit
  import debug_pkg::*;
#(
  parameter int DUMP_WORDS = 8,
  parameter int IDX_W      = 5
) (
  input logic                  clock,
  input logic                  reset,
  debug_command_unit_if.master bus
);

  state_t         r_state, w_next;
  logic [7:0]     r_cmd;
  logic [IDX_W:0] r_idx;
  logic           r_step_phase;
  logic           r_from_run;

  logic           w_rx_read, w_tx_write, w_pipe_enable;
  logic [7:0]     w_tx_data;
  logic           w_ser_start, w_ser_valid, w_ser_done, w_ser_busy;
  logic [7:0]     w_ser_data;
  logic [31:0]    w_ser_word;
  logic           w_last_word;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DUMP_WORDS);

  logic [31:0] r_cycles, r_cycles_snap;

  // Snapshot on dump entry (any entry except looping back from DUMP_SEND).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycles      <= 32'd0;
      r_cycles_snap <= 32'd0;
    end else begin
      if (w_pipe_enable)
        r_cycles <= r_cycles + 32'd1;
      if (w_next == ST_DUMP_WAIT && r_state != ST_DUMP_SEND)
        r_cycles_snap <= r_cycles;
    end
  end

  assign w_ser_word = (r_idx == LAST_IDX) ? r_cycles_snap : bus.dump_data;
`else
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DUMP_WORDS - 1);

  assign w_ser_word = bus.dump_data;
`endif

  assign w_last_word = (r_idx == LAST_IDX);
  assign w_ser_start = (r_state == ST_DUMP_SEND) && !w_ser_busy;

  debug_word_serializer u_ser (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_ser_start),
    .i_word  (w_ser_word),
    .o_data  (w_ser_data),
    .o_valid (w_ser_valid),
    .o_done  (w_ser_done),
    .o_busy  (w_ser_busy)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.rx_available) w_next = ST_DECODE;
      ST_DECODE: begin
        case (r_cmd)
          CMD_STEP: w_next = ST_STEP;
          CMD_RUN:  w_next = bus.program_done ? ST_DONE_RSP : ST_RUN;
          CMD_DUMP: w_next = ST_DUMP_WAIT;
          CMD_HALT: w_next = ST_HALT_RSP;
          default:  w_next = ST_ERR_RSP;
        endcase
      end
      ST_STEP:      if (r_step_phase) w_next = ST_DUMP_WAIT;
      ST_RUN: begin
        if (bus.program_done)
          w_next = ST_DONE_RSP;
        else if (bus.rx_available && bus.rx_data == CMD_HALT)
          w_next = ST_HALT_RSP;
      end
      ST_DONE_RSP:  w_next = ST_DUMP_WAIT;
      ST_HALT_RSP:  w_next = r_from_run ? ST_DUMP_WAIT : ST_IDLE;
      ST_ERR_RSP:   w_next = ST_IDLE;
      ST_DUMP_WAIT: w_next = ST_DUMP_SEND;
      ST_DUMP_SEND: if (w_ser_done) w_next = w_last_word ? ST_EOL : ST_DUMP_WAIT;
      ST_EOL:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_read     = 1'b0;
    w_tx_write    = 1'b0;
    w_tx_data     = 8'h00;
    w_pipe_enable = 1'b0;
    case (r_state)
      ST_IDLE:      w_rx_read = bus.rx_available;
      ST_STEP: begin
        w_pipe_enable = !r_step_phase;
        w_tx_write    = r_step_phase;
        w_tx_data     = r_step_phase ? RSP_STEP : 8'h00;
      end
      ST_RUN: begin
        w_pipe_enable = 1'b1;
        w_rx_read     = bus.rx_available;
      end
      ST_DONE_RSP:  begin w_tx_write = 1'b1; w_tx_data = RSP_END;  end
      ST_HALT_RSP:  begin w_tx_write = 1'b1; w_tx_data = RSP_HALT; end
      ST_ERR_RSP:   begin w_tx_write = 1'b1; w_tx_data = RSP_ERR;  end
      ST_DUMP_SEND: begin w_tx_write = w_ser_valid; w_tx_data = w_ser_data; end
      ST_EOL:       begin w_tx_write = 1'b1; w_tx_data = RSP_EOL;  end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmd        <= 8'h00;
      r_idx        <= '0;
      r_step_phase <= 1'b0;
      r_from_run   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.rx_available)
        r_cmd <= bus.rx_data;
      r_step_phase <= (r_state == ST_STEP) && !r_step_phase;
      if (r_state != ST_HALT_RSP)
        r_from_run <= (r_state == ST_RUN);
      if (r_state == ST_DUMP_SEND && w_ser_done)
        r_idx <= w_last_word ? '0 : r_idx + 1'b1;
    end
  end

  // Combinational strobes are masked during reset so an abort emits nothing.
  assign bus.rx_read     = w_rx_read & ~reset;
  assign bus.tx_write    = w_tx_write & ~reset;
  assign bus.tx_data     = w_tx_data;
  assign bus.pipe_enable = w_pipe_enable & ~reset;
  assign bus.dump_index  = r_idx[IDX_W-1:0];
  assign bus.busy        = (r_state != ST_IDLE) & ~reset;

endmodule

// File: tb/tb_debug_command_unit.sv
// tb/tb_debug_command_unit.sv - directed self-checking bench for debug_command_unit
module tb_debug_command_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  debug_command_unit_if #(.IDX_W(5)) bus ();

  debug_command_unit #(.DUMP_WORDS(8), .IDX_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  int         total = 0;
  int         bad = 0;
  int         pe_cnt = 0;
  logic       pop_pend = 1'b0;
  logic [4:0] last_idx = 5'd0;
  logic       s_busy = 1'b0;
  logic       s_rx_read = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: environment updates just after the edge, DUT outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
    bus.dump_data    = 32'h1000_0000 + {27'd0, last_idx};
    last_idx         = bus.dump_index;
    bus.rx_available = (rxq.size() != 0);
    bus.rx_data      = (rxq.size() != 0) ? rxq[0] : 8'h00;
    @(negedge clock);
    s_busy    = bus.busy;
    s_rx_read = bus.rx_read;
    if (bus.tx_write) txq.push_back(bus.tx_data);
    if (bus.pipe_enable) pe_cnt++;
    pop_pend = bus.rx_read;
  endtask

  task automatic run_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      if (!s_busy && !s_rx_read && rxq.size() == 0) done = 1'b1;
    end
    check({tag, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  task automatic exp_dump(input logic [31:0] cnt);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = 32'h1000_0000 + i;
      expq.push_back(w[31:24]);
      expq.push_back(w[23:16]);
      expq.push_back(w[15:8]);
      expq.push_back(w[7:0]);
    end
`ifdef DEBUG_CYCLE_COUNT_EN
    expq.push_back(cnt[31:24]);
    expq.push_back(cnt[23:16]);
    expq.push_back(cnt[15:8]);
    expq.push_back(cnt[7:0]);
`else
    w = cnt;
`endif
    expq.push_back(8'h0A);
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_len"}, 32'(txq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < txq.size())
        check($sformatf("%s_b%0d", tag, i), {24'd0, txq[i]}, {24'd0, expq[i]});
    txq.delete();
    expq.delete();
  endtask

  initial begin
    bit hit;
    reset            = 1'b1;
    bus.rx_available = 1'b0;
    bus.rx_data      = 8'h00;
    bus.program_done = 1'b0;
    bus.dump_data    = 32'd0;
    repeat (3) cyc();
    check("rst_tx_write", {31'd0, bus.tx_write}, 32'd0);
    check("rst_rx_read", {31'd0, bus.rx_read}, 32'd0);
    check("rst_pipe_enable", {31'd0, bus.pipe_enable}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_dump_index", {27'd0, bus.dump_index}, 32'd0);
    reset = 1'b0;
    txq.delete();
    pe_cnt = 0;

    // Plain dump
    rxq.push_back(8'h44);
    exp_dump(32'd0);
    run_idle("dump");
    cmp_tx("dump");
    check("dump_pe", 32'(pe_cnt), 32'd0);
    check("dump_index_idle", {27'd0, bus.dump_index}, 32'd0);

    // Single step
    pe_cnt = 0;
    rxq.push_back(8'h53);
    expq.push_back(8'h53);
    exp_dump(32'd1);
    run_idle("step");
    cmp_tx("step");
    check("step_pe", 32'(pe_cnt), 32'd1);

    // Run until program_done after 20 enabled cycles
    pe_cnt = 0;
    hit = 1'b0;
    rxq.push_back(8'h43);
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      if (pe_cnt == 20) hit = 1'b1;
    end
    check("run_reach20", {31'd0, hit}, 32'd1);
    bus.program_done = 1'b1;
    cyc();
    bus.program_done = 1'b0;
    expq.push_back(8'h45);
    exp_dump(32'd21);
    run_idle("run_done");
    cmp_tx("run_done");
    check("run_done_pe", 32'(pe_cnt), 32'd20);

    // Run, then a junk byte and a halt while running
    pe_cnt = 0;
    hit = 1'b0;
    rxq.push_back(8'h43);
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      if (pe_cnt == 3) hit = 1'b1;
    end
    check("halt_reach3", {31'd0, hit}, 32'd1);
    rxq.push_back(8'h41);
    rxq.push_back(8'h48);
    expq.push_back(8'h48);
    exp_dump(32'd26);
    run_idle("run_halt");
    cmp_tx("run_halt");
    check("run_halt_pe", 32'(pe_cnt), 32'd5);

    // Unknown command
    pe_cnt = 0;
    rxq.push_back(8'h7A);
    expq.push_back(8'h3F);
    run_idle("err");
    cmp_tx("err");
    check("err_pe", 32'(pe_cnt), 32'd0);

    // Run with program_done already set
    pe_cnt = 0;
    bus.program_done = 1'b1;
    rxq.push_back(8'h43);
    expq.push_back(8'h45);
    exp_dump(32'd26);
    run_idle("run_pre");
    bus.program_done = 1'b0;
    cmp_tx("run_pre");
    check("run_pre_pe", 32'(pe_cnt), 32'd0);

    // Halt from idle
    pe_cnt = 0;
    rxq.push_back(8'h48);
    expq.push_back(8'h48);
    run_idle("halt_idle");
    cmp_tx("halt_idle");

    // Reset during a dump after the third byte
    pe_cnt = 0;
    hit = 1'b0;
    rxq.push_back(8'h44);
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      if (txq.size() == 3) hit = 1'b1;
    end
    check("abort_reach3", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    cyc();
    check("abort_tx_write", {31'd0, bus.tx_write}, 32'd0);
    check("abort_pipe_enable", {31'd0, bus.pipe_enable}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_dump_index", {27'd0, bus.dump_index}, 32'd0);
    reset = 1'b0;
    repeat (10) cyc();
    check("abort_tx_count", 32'(txq.size()), 32'd3);
    check("abort_busy_after", {31'd0, bus.busy}, 32'd0);
    check("abort_pe", 32'(pe_cnt), 32'd0);
    txq.delete();

    // Dump again after reset; cycle counter restarts from zero
    rxq.push_back(8'h44);
    exp_dump(32'd0);
    run_idle("dump2");
    cmp_tx("dump2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
